// File: rtl/mem_stage_ctrl.sv
// MEM-stage pipeline controller: sequences the data-memory handshake around the
// EX/MEM register and derives pipeline enables, flushes and branch redirect.
module mem_stage_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CW       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exm_mem_read,
    input  logic        exm_mem_write,
    input  logic        exm_branch,
    input  logic        exm_zero,
    input  logic [31:0] exm_branch_target,
    input  logic [31:0] exm_alu_result,
    input  logic [31:0] exm_rt_data,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        pc_src,
    output logic [31:0] pc_target,
    output logic        mem_error
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone, StError} state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            mem_op;
    logic            mem_stall;
    logic            branch_taken;
    logic            load_use;

    assign mem_op = exm_mem_read | exm_mem_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_data <= '0;
            mem_error <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (mem_op) begin
                        state     <= StAccess;
                        mem_req   <= 1'b1;
                        mem_we    <= exm_mem_write;
                        mem_addr  <= exm_alu_result;
                        mem_wdata <= exm_rt_data;
                    end
                end
                StAccess: begin
                    if (mem_ready) begin
                        state    <= StDone;
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        if (!mem_we) begin
                            load_data <= mem_rdata;
                        end
                    end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        state     <= StError;
                        mem_req   <= 1'b0;
                        mem_error <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                StError: begin
                    state <= StError;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // DONE is deliberately absent: that cycle lets EX/MEM advance past the finished op.
    assign mem_stall    = ((state == StIdle) & mem_op) | (state == StAccess) |
                          (state == StError);
    assign branch_taken = exm_branch & exm_zero & ~mem_stall;
    assign load_use     = idex_mem_read & (idex_rt != 5'd0) &
                          ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    assign pc_target    = exm_branch_target;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        pc_src       = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_flush = 1'b1;
            end else if (branch_taken) begin
                pc_src       = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl: a transaction-level driver predicts every
// output cycle by cycle and one negedge process compares the DUT against it.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exm_mem_read, exm_mem_write, exm_branch, exm_zero;
    logic [31:0] exm_branch_target, exm_alu_result, exm_rt_data;
    logic        idex_mem_read;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, load_data, pc_target;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        pc_src, mem_error;

    mem_stage_ctrl #(.MAX_WAIT(16), .CW(8)) dut (
        .clk(clk), .reset(reset),
        .exm_mem_read(exm_mem_read), .exm_mem_write(exm_mem_write),
        .exm_branch(exm_branch), .exm_zero(exm_zero),
        .exm_branch_target(exm_branch_target), .exm_alu_result(exm_alu_result),
        .exm_rt_data(exm_rt_data), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .load_data(load_data), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .pc_src(pc_src),
        .pc_target(pc_target), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int req_hi_cnt = 0;
    int exm_lo_cnt = 0;
    bit chk_en     = 1'b0;

    // Expected registered state and whether the memory side is holding the pipe
    logic        exp_rst, exp_req, exp_we, exp_err, exp_stall;
    logic [31:0] exp_addr, exp_wdata, exp_load;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Order: pc_en if_id_en id_ex_en ex_mem_en | if_id id_ex ex_mem mem_wb flush | pc_src
    function automatic logic [8:0] model_ctrl(input logic rst, input logic stall,
                                              input logic br, input logic z,
                                              input logic imr, input logic [4:0] irt,
                                              input logic [4:0] rs, input logic [4:0] rt);
        if (rst)            return 9'b1111_0000_0;
        if (stall)          return 9'b0000_0001_0;
        if (br && z)        return 9'b1111_1110_1;
        if (imr && irt != 5'd0 && (irt == rs || irt == rt))
                            return 9'b0011_0100_0;
        return 9'b1111_0000_0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", mem_req, exp_req);
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_wdata);
            chk("load_data", load_data, exp_load);
            chk("mem_error", mem_error, exp_err);
            chk("pc_target", pc_target, exm_branch_target);
            chk("ctrl", {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
                         ex_mem_flush, mem_wb_flush, pc_src},
                model_ctrl(exp_rst, exp_stall, exm_branch, exm_zero, idex_mem_read,
                           idex_rt, ifid_rs, ifid_rt));
            if (mem_req === 1'b1) req_hi_cnt++;
            if (ex_mem_en === 1'b0) exm_lo_cnt++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rst_exp();
        exp_rst = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_err = 1'b0; exp_stall = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_load = '0;
    endtask

    task automatic rand_side();
        idex_mem_read     = 1'($urandom_range(0, 1));
        idex_rt           = 5'($urandom_range(0, 3));
        ifid_rs           = 5'($urandom_range(0, 3));
        ifid_rt           = 5'($urandom_range(0, 3));
        exm_zero          = 1'($urandom_range(0, 1));
        exm_branch_target = $urandom;
        mem_rdata         = $urandom;
        mem_ready         = 1'($urandom_range(0, 1));
    endtask

    task automatic plain(input logic br, input logic z, input logic [31:0] tgt,
                         input logic imr, input logic [4:0] irt,
                         input logic [4:0] rs, input logic [4:0] rt);
        exm_mem_read = 1'b0; exm_mem_write = 1'b0; exm_branch = br; exm_zero = z;
        exm_branch_target = tgt; idex_mem_read = imr; idex_rt = irt;
        ifid_rs = rs; ifid_rt = rt; mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom; exp_stall = 1'b0;
    endtask

    // d = ACCESS cycles up to and including the one where mem_ready is seen
    task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int d, input logic br);
        rand_side();
        exm_mem_read = rd; exm_mem_write = wr; exm_alu_result = addr;
        exm_rt_data = wdata; exm_branch = br; exp_stall = 1'b1;
        next_cycle();
        for (int k = 1; k <= d; k++) begin
            rand_side();
            mem_ready = (k == d);
            if (k == d) mem_rdata = rdata;
            exp_req = 1'b1; exp_we = wr; exp_addr = addr; exp_wdata = wdata;
            exp_stall = 1'b1;
            next_cycle();
        end
        rand_side();
        exp_req = 1'b0; exp_stall = 1'b0;
        if (!wr) exp_load = rdata;
        next_cycle();
    endtask

    int base_req, base_lo;
    logic [31:0] a, w;

    initial begin
        reset = 1'b1;
        plain(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        exm_alu_result = '0; exm_rt_data = '0;
        set_rst_exp();
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_req", mem_req, 32'd0);
        chk("reset_pc_en", pc_en, 32'd1);
        next_cycle();
        reset = 1'b0; exp_rst = 1'b0;
        plain(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        next_cycle();

        base_req = req_hi_cnt; base_lo = exm_lo_cnt;
        mem_op(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 3, 1'b0);
        chk("ld_req_cycles", req_hi_cnt - base_req, 32'd3);
        chk("ld_stall_cycles", exm_lo_cnt - base_lo, 32'd4);
        chk("ld_data", load_data, 32'hDEADBEEF);

        base_req = req_hi_cnt; base_lo = exm_lo_cnt;
        mem_op(1'b0, 1'b1, 32'h10, 32'h1234, 32'h5555AAAA, 1, 1'b0);
        chk("st_req_cycles", req_hi_cnt - base_req, 32'd1);
        chk("st_stall_cycles", exm_lo_cnt - base_lo, 32'd2);
        chk("st_wdata", mem_wdata, 32'h1234);
        chk("st_we", mem_we, 32'd1);
        chk("st_load_kept", load_data, 32'hDEADBEEF);

        plain(1'b1, 1'b1, 32'h100, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        chk("br_pc_src", pc_src, 32'd1);
        chk("br_target", pc_target, 32'h100);
        chk("br_flush", {if_id_flush, id_ex_flush, ex_mem_flush}, 32'd7);
        next_cycle();
        plain(1'b1, 1'b0, 32'h100, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        chk("nbr_flush", {if_id_flush, id_ex_flush, ex_mem_flush, pc_src}, 32'd0);
        next_cycle();

        plain(1'b0, 1'b0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd9);
        @(negedge clk);
        chk("lu_stall", {pc_en, if_id_en, id_ex_flush}, 32'b001);
        next_cycle();
        plain(1'b0, 1'b0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        chk("lu_r0", {pc_en, if_id_en, id_ex_flush}, 32'b110);
        next_cycle();

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) < 2) begin
                logic rd, wr;
                int   sel;
                sel = int'($urandom_range(0, 4));
                rd  = (sel != 1);
                wr  = (sel == 1) || (sel == 4);
                mem_op(rd, wr, $urandom, $urandom, $urandom,
                       int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
            end else begin
                rand_side();
                exm_mem_read = 1'b0; exm_mem_write = 1'b0;
                exm_branch = 1'($urandom_range(0, 1)); exp_stall = 1'b0;
                next_cycle();
            end
        end

        // Reset landing in the second ACCESS cycle
        a = 32'hA0A0_0004; w = 32'h0BAD_F00D;
        rand_side();
        exm_mem_read = 1'b1; exm_mem_write = 1'b0; exm_branch = 1'b0;
        exm_alu_result = a; exm_rt_data = w; exp_stall = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = a; exp_wdata = w;
        next_cycle();
        mem_ready = 1'b0;
        reset = 1'b1;
        set_rst_exp();
        @(negedge clk);
        chk("rst_mid_req", mem_req, 32'd0);
        next_cycle();
        plain(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        next_cycle();
        reset = 1'b0; exp_rst = 1'b0;
        @(negedge clk);
        chk("rst_load_data", load_data, 32'd0);
        next_cycle();

        // Timeout into ERROR, then recovery by reset
        a = 32'h0000_0C00; w = 32'h7777_0000;
        rand_side();
        exm_mem_read = 1'b1; exm_mem_write = 1'b0; exm_branch = 1'b0;
        exm_alu_result = a; exm_rt_data = w; exp_stall = 1'b1;
        next_cycle();
        base_req = req_hi_cnt;
        for (int k = 1; k <= 16; k++) begin
            rand_side();
            mem_ready = 1'b0;
            exp_req = 1'b1; exp_we = 1'b0; exp_addr = a; exp_wdata = w; exp_stall = 1'b1;
            next_cycle();
        end
        for (int k = 0; k < 4; k++) begin
            rand_side();
            exm_branch = 1'($urandom_range(0, 1));
            exp_req = 1'b0; exp_err = 1'b1; exp_stall = 1'b1;
            next_cycle();
        end
        chk("err_req_cycles", req_hi_cnt - base_req, 32'd16);
        rand_side();
        @(negedge clk);
        chk("err_flag", mem_error, 32'd1);
        chk("err_hold", {pc_en, if_id_en, id_ex_en, ex_mem_en}, 32'd0);
        next_cycle();
        reset = 1'b1;
        set_rst_exp();
        @(negedge clk);
        chk("err_reset_flag", mem_error, 32'd0);
        chk("err_reset_pc_en", pc_en, 32'd1);
        next_cycle();
        plain(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        next_cycle();
        reset = 1'b0; exp_rst = 1'b0;
        next_cycle();

        mem_op(1'b1, 1'b0, 32'h44, 32'h0, 32'hCAFE0001, 2, 1'b1);
        chk("post_err_load", load_data, 32'hCAFE0001);
        plain(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        next_cycle();
        next_cycle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
